// File: rtl/wqe_table.sv
// Indexed WQE slot store: doorbell-side writes, consuming reads for the tx engine.
// Reads pass a two-stage pipeline into a credit-managed response FIFO.
module wqe_table #(
   parameter int unsigned WQE_INDEX_WIDTH     = 10,
   parameter int unsigned AXIS_WQE_DATA_WIDTH = 256,
   parameter int unsigned QPN_WIDTH           = 24,
   parameter int unsigned OUT_FIFO_DEPTH      = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [WQE_INDEX_WIDTH-1:0]     s_axis_wqe_wr_index,
   input  logic [AXIS_WQE_DATA_WIDTH-1:0] s_axis_wqe_wr_data,
   input  logic [QPN_WIDTH-1:0]           s_axis_wqe_wr_qpn,
   input  logic                           s_axis_wqe_wr_valid,
   output logic                           s_axis_wqe_wr_ready,
   input  logic [WQE_INDEX_WIDTH-1:0]     s_axis_wqe_req_id,
   input  logic                           s_axis_wqe_req_valid,
   output logic                           s_axis_wqe_req_ready,
   output logic [AXIS_WQE_DATA_WIDTH-1:0] m_axis_wqe_data,
   output logic [QPN_WIDTH-1:0]           m_axis_wqe_qpn,
   output logic [WQE_INDEX_WIDTH-1:0]     m_axis_wqe_id,
   output logic                           m_axis_wqe_err,
   output logic                           m_axis_wqe_valid,
   input  logic                           m_axis_wqe_ready,
   output logic [WQE_INDEX_WIDTH:0]       entry_count
);

   localparam int unsigned DEPTH   = 2 ** WQE_INDEX_WIDTH;
   localparam int unsigned ENTRY_W = QPN_WIDTH + AXIS_WQE_DATA_WIDTH;
   localparam int unsigned RESP_W  = 1 + WQE_INDEX_WIDTH + ENTRY_W;
   localparam int unsigned PTR_W   = $clog2(OUT_FIFO_DEPTH);
   localparam int unsigned CRD_W   = PTR_W + 2;
   localparam logic [WQE_INDEX_WIDTH:0] CNT_ONE = 1;
   localparam logic [PTR_W:0]           PTR_ONE = 1;

   logic [ENTRY_W-1:0]         ram [DEPTH];
   logic [DEPTH-1:0]           valid_q, valid_d;
   logic [WQE_INDEX_WIDTH:0]   count_q, count_d;
   logic                       wr_fire, req_fire, wr_new, req_hit;

   logic                       s1_valid_q, s1_err_q;
   logic [WQE_INDEX_WIDTH-1:0] s1_id_q;
   logic [ENTRY_W-1:0]         rd_q;

   logic [RESP_W-1:0]          fifo_mem [OUT_FIFO_DEPTH];
   logic [PTR_W:0]             wr_ptr_q, rd_ptr_q, fifo_count;
   logic [RESP_W-1:0]          head;
   logic                       fifo_pop;
   logic [CRD_W-1:0]           credit_used;

   assign s_axis_wqe_wr_ready  = ~rst;
   assign fifo_count           = wr_ptr_q - rd_ptr_q;
   // Every accepted request not yet popped holds a FIFO slot, so the FIFO never overflows.
   assign credit_used          = CRD_W'(fifo_count) + CRD_W'(s1_valid_q);
   assign s_axis_wqe_req_ready = ~rst && (credit_used < CRD_W'(OUT_FIFO_DEPTH));
   assign wr_fire              = s_axis_wqe_wr_valid && s_axis_wqe_wr_ready;
   assign req_fire             = s_axis_wqe_req_valid && s_axis_wqe_req_ready;
   assign entry_count          = count_q;

   always_comb begin
      valid_d = valid_q;
      if (req_fire) valid_d[s_axis_wqe_req_id] = 1'b0;
      if (wr_fire)  valid_d[s_axis_wqe_wr_index] = 1'b1;
      // A same-slot write re-validates the slot, so that request does not decrement.
      wr_new  = wr_fire && !valid_q[s_axis_wqe_wr_index];
      req_hit = req_fire && valid_q[s_axis_wqe_req_id] &&
                !(wr_fire && (s_axis_wqe_wr_index == s_axis_wqe_req_id));
      count_d = count_q;
      if (wr_new && !req_hit)      count_d = count_q + CNT_ONE;
      else if (req_hit && !wr_new) count_d = count_q - CNT_ONE;
   end

   always_ff @(posedge clk) begin
      if (wr_fire) ram[s_axis_wqe_wr_index] <= {s_axis_wqe_wr_qpn, s_axis_wqe_wr_data};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_q <= '0;
      end else if (req_fire) begin
         rd_q <= ram[s_axis_wqe_req_id];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q    <= '0;
         count_q    <= '0;
         s1_valid_q <= 1'b0;
         s1_id_q    <= '0;
         s1_err_q   <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
      end else begin
         valid_q    <= valid_d;
         count_q    <= count_d;
         s1_valid_q <= req_fire;
         if (req_fire) begin
            s1_id_q  <= s_axis_wqe_req_id;
            s1_err_q <= ~valid_q[s_axis_wqe_req_id];
         end
         if (s1_valid_q) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (fifo_pop)   rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (s1_valid_q) fifo_mem[wr_ptr_q[PTR_W-1:0]] <= {s1_err_q, s1_id_q, rd_q};
   end

   assign head             = fifo_mem[rd_ptr_q[PTR_W-1:0]];
   assign m_axis_wqe_valid = (fifo_count != '0);
   assign fifo_pop         = m_axis_wqe_valid && m_axis_wqe_ready;

   // Outputs are forced to zero while empty so stale FIFO storage never shows.
   always_comb begin
      m_axis_wqe_err  = 1'b0;
      m_axis_wqe_id   = '0;
      m_axis_wqe_qpn  = '0;
      m_axis_wqe_data = '0;
      if (m_axis_wqe_valid) begin
         {m_axis_wqe_err, m_axis_wqe_id, m_axis_wqe_qpn, m_axis_wqe_data} = head;
      end
   end

endmodule
